// File: rtl/jtag_ir_param.sv
// jtag_ir_param -- parametrised JTAG instruction register for the TAP.
//
// Sits between the TAP controller strobes and the DR select logic.
// Shift register captures {capture_status, 2'b01}, shifts LSB-out/MSB-in,
// and is copied into the instruction latch on update_ir. The one-hot select
// outputs are registered from the *next* latch value, so they are valid in
// the same cycle that ir_updated pulses.
//
// Optional feature (macro JTAG_IR_LEN_CHECK_EN): an update after fewer than
// IR_WIDTH shift cycles is refused and raises the sticky ir_len_err. Without
// the macro every update latches and ir_len_err is tied low.
//
// Ports:
//   clk, rst_n        TCK clock, async active-low reset
//   tlr               Test-Logic-Reset: synchronous force to RESET_IR
//   tdi / tdo         serial in / serial out (tdo = shift_reg[0])
//   capture_ir, shift_ir, update_ir   TAP strobes (priority tlr>cap>shift>upd)
//   capture_status    design status bits, loaded above the fixed 2'b01
//   ir_out            current latched instruction
//   sel_*             registered one-hot decode of ir_out
//   ir_updated        one-cycle pulse after a latch update
//   ir_len_err        sticky short-shift error
module jtag_ir_param #(
  parameter int                  IR_WIDTH  = 5,
  parameter logic [IR_WIDTH-1:0] RESET_IR  = 'h01,
  parameter logic [IR_WIDTH-1:0] IDCODE_OP = 'h01,
  parameter logic [IR_WIDTH-1:0] DTMCS_OP  = 'h10,
  parameter logic [IR_WIDTH-1:0] DMI_OP    = 'h11,
  parameter logic [IR_WIDTH-1:0] BYPASS_OP = '1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                tlr,
  input  logic                tdi,
  output logic                tdo,
  input  logic                capture_ir,
  input  logic                shift_ir,
  input  logic                update_ir,
  input  logic [IR_WIDTH-3:0] capture_status,
  output logic [IR_WIDTH-1:0] ir_out,
  output logic                sel_idcode,
  output logic                sel_dtmcs,
  output logic                sel_dmi,
  output logic                sel_bypass,
  output logic                ir_updated,
  output logic                ir_len_err
);

  logic [IR_WIDTH-1:0] r_shift;
  logic [IR_WIDTH-1:0] r_latch;
  logic [IR_WIDTH-1:0] w_latch_nxt;
  logic                w_do_upd;
  logic                w_upd_ok;
  logic                r_updated;
  logic [3:0]          r_sel;     // {bypass, dmi, dtmcs, idcode}

  // Unknown opcodes (including all-zero) fall through to bypass, so the
  // result is one-hot by construction.
  function automatic logic [3:0] decode(input logic [IR_WIDTH-1:0] op);
    if (op == IDCODE_OP)      decode = 4'b0001;
    else if (op == DTMCS_OP)  decode = 4'b0010;
    else if (op == DMI_OP)    decode = 4'b0100;
    else if (op == BYPASS_OP) decode = 4'b1000;
    else                      decode = 4'b1000;
  endfunction

`ifdef JTAG_IR_LEN_CHECK_EN
  localparam int CW = $clog2(IR_WIDTH + 1);
  logic [CW-1:0] r_cnt;
  logic          r_len_err;

  assign w_upd_ok   = (r_cnt == CW'(IR_WIDTH));
  assign ir_len_err = r_len_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_len_err <= 1'b0;
    end else if (tlr) begin
      r_cnt     <= '0;
      r_len_err <= 1'b0;
    end else if (capture_ir) begin
      r_cnt     <= '0;
    end else if (shift_ir) begin
      if (r_cnt != CW'(IR_WIDTH)) r_cnt <= r_cnt + 1'b1;
    end else if (update_ir && !w_upd_ok) begin
      r_len_err <= 1'b1;
    end
  end
`else
  assign w_upd_ok   = 1'b1;
  assign ir_len_err = 1'b0;
`endif

  // Next latch value; only an update with no higher-priority strobe latches.
  always_comb begin
    w_latch_nxt = r_latch;
    w_do_upd    = 1'b0;
    if (tlr) begin
      w_latch_nxt = RESET_IR;
    end else if (!capture_ir && !shift_ir && update_ir && w_upd_ok) begin
      w_latch_nxt = r_shift;
      w_do_upd    = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift   <= RESET_IR;
      r_latch   <= RESET_IR;
      r_updated <= 1'b0;
      r_sel     <= decode(RESET_IR);
    end else begin
      if (tlr)             r_shift <= RESET_IR;
      else if (capture_ir) r_shift <= {capture_status, 2'b01};
      else if (shift_ir)   r_shift <= {tdi, r_shift[IR_WIDTH-1:1]};
      r_latch   <= w_latch_nxt;
      r_updated <= w_do_upd;
      // Decode the value being latched so selects line up with ir_updated.
      r_sel     <= decode(w_latch_nxt);
    end
  end

  assign tdo        = r_shift[0];
  assign ir_out     = r_latch;
  assign ir_updated = r_updated;
  assign sel_idcode = r_sel[0];
  assign sel_dtmcs  = r_sel[1];
  assign sel_dmi    = r_sel[2];
  assign sel_bypass = r_sel[3];

endmodule

// File: tb/tb_jtag_ir_param.sv
module tb_jtag_ir_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  // 5-bit instance
  logic       tlr, tdi, cap, sh, upd;
  logic [2:0] cs;
  logic       tdo, s_id, s_dt, s_dm, s_by, updd, lerr;
  logic [4:0] ir;
  // 8-bit instance
  logic       tlr8, tdi8, cap8, sh8, upd8;
  logic [5:0] cs8;
  logic       tdo8, s_id8, s_dt8, s_dm8, s_by8, updd8, lerr8;
  logic [7:0] ir8;

  jtag_ir_param u_dut (
    .clk(clk), .rst_n(rst_n), .tlr(tlr), .tdi(tdi), .tdo(tdo),
    .capture_ir(cap), .shift_ir(sh), .update_ir(upd), .capture_status(cs),
    .ir_out(ir), .sel_idcode(s_id), .sel_dtmcs(s_dt), .sel_dmi(s_dm),
    .sel_bypass(s_by), .ir_updated(updd), .ir_len_err(lerr)
  );

  jtag_ir_param #(.IR_WIDTH(8), .RESET_IR(8'h01), .BYPASS_OP(8'hFF)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .tlr(tlr8), .tdi(tdi8), .tdo(tdo8),
    .capture_ir(cap8), .shift_ir(sh8), .update_ir(upd8), .capture_status(cs8),
    .ir_out(ir8), .sel_idcode(s_id8), .sel_dtmcs(s_dt8), .sel_dmi(s_dm8),
    .sel_bypass(s_by8), .ir_updated(updd8), .ir_len_err(lerr8)
  );

`ifdef JTAG_IR_LEN_CHECK_EN
  localparam bit LENCHK = 1'b1;
`else
  localparam bit LENCHK = 1'b0;
`endif

  int n_asrt = 0;
  int n_fail = 0;

  // Reference model of the 5-bit register, kept as plain integers.
  int m_sr, m_latch, m_cnt;
  bit m_upd, m_err;

  function automatic int sel_of(input int op);
    case (op)
      1:       return 1;   // IDCODE
      16:      return 2;   // DTMCS
      17:      return 4;   // DMI
      default: return 8;   // BYPASS
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_sr = 1; m_latch = 1; m_cnt = 0; m_upd = 0; m_err = 0;
  endtask

  task automatic check_all(input string tag);
    check({tag, "_tdo"}, 32'(tdo), 32'(m_sr & 1));
    check({tag, "_ir"},  32'(ir), 32'(m_latch));
    check({tag, "_sel"}, 32'({s_by, s_dm, s_dt, s_id}), 32'(sel_of(m_latch)));
    check({tag, "_upd"}, 32'(updd), 32'(m_upd));
    check({tag, "_err"}, 32'(lerr), 32'(LENCHK ? m_err : 1'b0));
  endtask

  // One clock with the given strobes; called at a negedge, returns at the next.
  task automatic cyc(input string tag, input bit t, input bit c, input bit s,
                     input bit u, input bit d, input logic [2:0] st);
    tlr = t; cap = c; sh = s; upd = u; tdi = d; cs = st;
    if (t) begin
      m_sr = 1; m_latch = 1; m_cnt = 0; m_err = 0; m_upd = 0;
    end else if (c) begin
      m_sr = (int'(st) << 2) | 1; m_cnt = 0; m_upd = 0;
    end else if (s) begin
      m_sr = (m_sr >> 1) | (int'(d) << 4);
      m_cnt = (m_cnt < 5) ? m_cnt + 1 : 5;
      m_upd = 0;
    end else if (u) begin
      if (LENCHK && m_cnt < 5) begin
        m_err = 1; m_upd = 0;
      end else begin
        m_latch = m_sr; m_upd = 1;
      end
    end else begin
      m_upd = 0;
    end
    @(posedge clk);
    @(negedge clk);
    tlr = 0; cap = 0; sh = 0; upd = 0; tdi = 0;
    check_all(tag);
  endtask

  task automatic shift_val(input string tag, input int v, input int n);
    for (int i = 0; i < n; i++) cyc(tag, 0, 0, 1, 0, 1'((v >> i) & 1), 3'b0);
  endtask

  task automatic load(input string tag, input int v);
    cyc(tag, 0, 1, 0, 0, 0, 3'($urandom));
    shift_val(tag, v, 5);
    cyc(tag, 0, 0, 0, 1, 0, 3'b0);
  endtask

  logic [4:0] seq;
  logic [7:0] exp8;

  initial begin
    rst_n = 0;
    tlr = 0; cap = 0; sh = 0; upd = 0; tdi = 0; cs = 0;
    tlr8 = 0; cap8 = 0; sh8 = 0; upd8 = 0; tdi8 = 0; cs8 = 0;
    model_reset();
    @(negedge clk); @(negedge clk);
    rst_n = 1;
    check_all("reset");
    check("reset_ir", 32'(ir), 32'h01);
    check("reset_idcode", 32'(s_id), 32'd1);

    // Capture status 101 -> shift_reg 10101, shifted out LSB first.
    seq = 5'b10101;
    cyc("cap", 0, 1, 0, 0, 0, 3'b101);
    check("cap_tdo0", 32'(tdo), 32'(seq[0]));
    for (int i = 1; i < 5; i++) begin
      cyc("capsh", 0, 0, 1, 0, 0, 3'b0);
      check("cap_tdo_seq", 32'(tdo), 32'(seq[i]));
      check("cap_ir_stable", 32'(ir), 32'h01);
    end

    // DMI opcode, ir_updated pulses exactly once.
    load("dmi", 5'h11);
    check("dmi_ir", 32'(ir), 32'h11);
    check("dmi_sel", 32'(s_dm), 32'd1);
    check("dmi_upd", 32'(updd), 32'd1);
    cyc("dmi_idle", 0, 0, 0, 0, 0, 3'b0);
    check("dmi_upd_drop", 32'(updd), 32'd0);

    // Unmapped opcode -> bypass; tlr restores IDCODE.
    load("unmapped", 5'h07);
    check("unmapped_byp", 32'(s_by), 32'd1);
    cyc("tlr", 1, 0, 0, 0, 0, 3'b0);
    check("tlr_ir", 32'(ir), 32'h01);
    check("tlr_idcode", 32'(s_id), 32'd1);

    // Short shift, then a full DTMCS load, then tlr.
    cyc("short", 0, 1, 0, 0, 0, 3'b010);
    shift_val("short", 5'b00110, 3);
    cyc("short_upd", 0, 0, 0, 1, 0, 3'b0);
    load("dtmcs", 5'h10);
    check("dtmcs_sel", 32'(s_dt), 32'd1);
    check("dtmcs_err_sticky", 32'(lerr), 32'(LENCHK));
    cyc("tlr2", 1, 0, 0, 0, 0, 3'b0);
    check("tlr2_err", 32'(lerr), 32'd0);

    // All-zero opcode, over-length shift, simultaneous strobes.
    load("zero", 5'h00);
    check("zero_byp", 32'(s_by), 32'd1);
    cyc("over", 0, 1, 0, 0, 0, 3'b0);
    shift_val("over", 9'h1A3, 9);
    cyc("over_upd", 0, 0, 0, 1, 0, 3'b0);
    check("over_ir", 32'(ir), 32'h1A);
    cyc("prio_all", 1, 1, 1, 1, 1, 3'b111);
    cyc("prio_cap", 0, 1, 1, 1, 1, 3'b110);
    cyc("prio_sh", 0, 0, 1, 1, 1, 3'b0);

    // Random strobe traffic against the model.
    for (int k = 0; k < 400; k++) begin
      int r;
      r = int'($urandom_range(0, 15));
      cyc("rand", r == 0, r >= 1 && r <= 2, r >= 3 && r <= 10, r >= 11 && r <= 13,
          1'($urandom), 3'($urandom));
    end

    // 8-bit instance: capture, shift out, load all ones.
    check("w8_reset_ir", 32'(ir8), 32'h01);
    check("w8_reset_id", 32'(s_id8), 32'd1);
    cs8 = 6'($urandom);
    exp8 = {cs8, 2'b01};
    cap8 = 1; @(posedge clk); @(negedge clk); cap8 = 0;
    for (int i = 0; i < 8; i++) begin
      check("w8_tdo", 32'(tdo8), 32'((exp8 >> i) & 8'h1));
      sh8 = 1; tdi8 = 1; @(posedge clk); @(negedge clk); sh8 = 0; tdi8 = 0;
    end
    check("w8_ir_stable", 32'(ir8), 32'h01);
    upd8 = 1; @(posedge clk); @(negedge clk); upd8 = 0;
    check("w8_ir_ff", 32'(ir8), 32'hFF);
    check("w8_sel", 32'({s_by8, s_dm8, s_dt8, s_id8}), 32'h8);
    check("w8_upd", 32'(updd8), 32'd1);

    // Mid-shift async reset pulse.
    for (int i = 0; i < 3; i++) begin
      sh8 = 1; tdi8 = 0; @(posedge clk); @(negedge clk); sh8 = 0;
    end
    rst_n = 0;
    #1;
    check("w8_rst_ir", 32'(ir8), 32'h01);
    check("w8_rst_tdo", 32'(tdo8), 32'd1);
    rst_n = 1;
    @(negedge clk);
    check("w8_rst_sel", 32'({s_by8, s_dm8, s_dt8, s_id8}), 32'h1);
    check("w8_rst_upd", 32'(updd8), 32'd0);
    model_reset();
    check_all("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule

// File: doc/jtag_ir_param.md
Name: jtag_ir_param

Overview:
- Parametrised JTAG instruction register for the TAP. Successor to the fixed 5-bit IR.
- Configurable IR width, reset instruction and opcode map.
- Design-specific capture status bits.
- Registered one-hot instruction decode: unknown opcodes map to BYPASS, per IEEE 1149.1.
- Update-done pulse for downstream DR muxing.
- Sits between the TAP controller (capture/shift/update/tlr strobes) and the DR select logic.

Parameters:
- IR_WIDTH, 5, instruction register length in bits; legal range 2..16.
- RESET_IR, 'h01, instruction loaded on reset and on tlr (IDCODE); IR_WIDTH bits.
- IDCODE_OP, 'h01, opcode decoded to sel_idcode.
- DTMCS_OP, 'h10, opcode decoded to sel_dtmcs.
- DMI_OP, 'h11, opcode decoded to sel_dmi.
- BYPASS_OP, all ones (IR_WIDTH bits), opcode decoded to sel_bypass.

Ports:
- clk  input  1  TCK-domain clock
- rst_n  input  1  asynchronous active-low reset
- tlr  input  1  TAP in Test-Logic-Reset; synchronous force to RESET_IR
- tdi  input  1  serial data in
- tdo  output  1  serial data out, equal to shift_reg[0] (combinational)
- capture_ir  input  1  Capture-IR strobe
- shift_ir  input  1  Shift-IR strobe
- update_ir  input  1  Update-IR strobe
- capture_status  input  IR_WIDTH-2  loaded into shift_reg[IR_WIDTH-1:2] on capture
- ir_out  output  IR_WIDTH  current latched instruction
- sel_idcode, sel_dtmcs, sel_dmi, sel_bypass  output  1 each  registered one-hot decode of ir_out
- ir_updated  output  1  one-cycle pulse after a latch update
- ir_len_err  output  1  sticky short-shift error (optional feature only; otherwise tied 0)

Behaviour:
- Reset (rst_n=0, async):
  - shift_reg=RESET_IR, ir_latch=RESET_IR.
  - sel_idcode=1 if RESET_IR==IDCODE_OP; other selects decoded accordingly.
  - ir_updated=0, shift_cnt=0, ir_len_err=0.
- Per-cycle priority: tlr > capture_ir > shift_ir > update_ir. Simultaneous strobes are a TAP protocol error; the priority defines the result.
- tlr:
  - ir_latch=RESET_IR, shift_reg=RESET_IR, shift_cnt=0.
  - ir_len_err cleared; selects re-decoded next cycle.
  - ir_updated=0.
- capture_ir:
  - shift_reg={capture_status, 2'b01}; shift_cnt=0.
  - ir_latch unchanged.
- shift_ir:
  - shift_reg={tdi, shift_reg[IR_WIDTH-1:1]}.
  - shift_cnt increments, saturating at IR_WIDTH.
  - tdo reflects the new LSB after the edge.
- update_ir:
  - ir_latch=shift_reg (subject to the optional check).
  - ir_updated=1 for exactly the following cycle.
- Decode:
  - Registered from ir_latch; valid the same cycle ir_updated is high.
  - Exactly one select is high at all times.
  - Any opcode not equal to IDCODE_OP, DTMCS_OP or DMI_OP asserts sel_bypass. All-zero opcode also maps to bypass.
- ir_out:
  - Always the latch, never the shift register.
  - Stable through capture and shift.
- Shifting more than IR_WIDTH bits is legal; the last IR_WIDTH bits win.
- Reset asserted mid-shift aborts: latch returns to RESET_IR, partial shift is discarded.
- No state changes when no strobe is active.

Optional Feature:
- Macro: JTAG_IR_LEN_CHECK_EN.
- Defined:
  - On update_ir with shift_cnt < IR_WIDTH, ir_latch is NOT updated and ir_updated stays 0.
  - ir_len_err sets and stays set until tlr or rst_n.
  - Update with shift_cnt==IR_WIDTH (saturated) behaves normally and does not clear ir_len_err.
- Undefined:
  - Update always latches regardless of shift count.
  - ir_len_err driven constant 0; shift_cnt logic may be omitted.

Test Plan:
- Reset, defaults -> release rst_n: ir_out=5'h01, sel_idcode=1, other selects 0, tdo=1, ir_updated=0.
- capture_status=3'b101, one capture_ir -> shift out 5 bits: tdo sequence 1,0,1,0,1 (LSB first, shift_reg=5'b10101); ir_out stays 5'h01.
- Capture, shift 5'h11 LSB first (tdi 1,0,0,0,1), update -> next cycle ir_out=5'h11, sel_dmi=1, ir_updated high for exactly one cycle.
- Shift 5'h07 (unmapped), update -> sel_bypass=1, ir_out=5'h07. Then assert tlr for 1 cycle -> ir_out=5'h01, sel_idcode=1.
- Short shift with JTAG_IR_LEN_CHECK_EN: capture, shift 3 bits, update -> ir_out unchanged, ir_updated=0, ir_len_err=1. Then full 5-bit shift of 5'h10 and update -> sel_dtmcs=1, ir_len_err still 1. tlr -> ir_len_err=0.
- Parameter sweep IR_WIDTH=8, BYPASS_OP=8'hFF: capture gives low bits 01; shift 8'hFF and update -> sel_bypass=1. Mid-shift rst_n pulse -> ir_out=RESET_IR.
